fetch_addr_gen: RTL
===================

# fetch_addr_gen

Parametrised fetch-address generator with an integrated direct-mapped branch target buffer (BTB). It succeeds the fixed 4-slot predict unit. Each cycle it presents one aligned fetch block: start PC, a per-slot valid mask, and a taken prediction. The next block address comes from the BTB or the sequential path. It sits between reset/backend redirect logic and the instruction-fetch stage, and hands blocks over with a valid/ready handshake.

## Interface
- FETCH_WIDTH, 4: instructions per fetch block; power of 2, ≥2.
- BTB_ENTRIES, 16: BTB entries; power of 2, ≥2.
- RESET_PC, 32'h1C00_0000: first fetch address.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- out_valid  out  1  fetch block valid.
- out_ready  in  1  fetch stage accepts block.
- out_pc  out  32  block start PC; may be mid-block.
- out_mask  out  FETCH_WIDTH  slot i valid.
- out_pred_taken  out  1  block ends in a predicted-taken branch.
- out_pred_slot  out  log2(FETCH_WIDTH)  slot of the predicted branch.
- out_pred_target  out  32  predicted target.
- redirect_valid  in  1  backend redirect.
- redirect_pc  in  32  redirect target.
- upd_valid  in  1  BTB training write.
- upd_pc  in  32  resolved branch PC.
- upd_target  in  32  resolved target.
- upd_taken  in  1  resolved direction.

## Operation
- Address split, with OW = log2(FETCH_WIDTH) and IW = log2(BTB_ENTRIES):
  - slot offset = pc[OW+1:2]
  - index = pc[OW+2 +: IW]
  - tag = pc[31:OW+2+IW]
  - pc[1:0] is ignored.
- BTB entry fields: valid, tag, slot, target[31:0], 2-bit saturating counter (0–1 not-taken, 2–3 taken).
- Lookup is combinational on the registered out_pc.
  - Hit = valid, tag match, entry.slot ≥ start offset, counter ≥ 2.
- On a hit:
  - out_pred_taken=1, out_pred_slot=entry.slot, out_pred_target=entry.target.
  - out_mask covers slots offset..entry.slot.
  - next PC = entry.target.
- On a miss:
  - out_pred_taken=0, out_pred_slot=0, out_pred_target=0.
  - out_mask covers slots offset..FETCH_WIDTH-1.
  - next PC = (out_pc with bits [OW+1:0] cleared) + FETCH_WIDTH*4, wrapping mod 2^32.
- State machine:
  - S_RESET → S_RUN on the first edge with rst=0.
  - S_RUN is held until rst.
  - out_valid=1 only in S_RUN.
- Next out_pc is chosen by priority:
  1. rst → RESET_PC.
  2. redirect_valid → redirect_pc.
  3. out_valid & out_ready → predicted next PC.
  4. Otherwise hold.
- Redirect overrides a same-cycle handshake. The block presented that cycle is dropped, and the consumer discards it.
- BTB update on upd_valid, at entry[index(upd_pc)]:
  - Tag match and valid: counter ±1 saturating per upd_taken. If taken, target and slot are rewritten.
  - Miss and upd_taken: allocate with valid=1, new tag/slot/target, counter=2.
  - Miss and not taken: no change.
- Reset clears all BTB valid bits; other BTB fields are don't-care.

## Timing
- Reset values:
  - out_valid=0, out_pc=RESET_PC.
  - Prediction outputs follow the BTB, which is empty after reset, so mask is a full miss mask and pred outputs are 0.
- out_valid rises on the first edge after rst deasserts, with out_pc=RESET_PC.
- Throughput is one block per cycle while out_ready=1. Handshake-to-next-out_pc latency is 1 cycle.
- Stall (out_valid & !out_ready): all out_* stay stable, unless a BTB update to the current index changes the prediction. Consumers sample only on handshake.
- redirect_valid at edge t puts out_pc=redirect_pc at t+1 with out_valid=1, even when stalled.
- Update/lookup collision in the same cycle: the lookup sees pre-update contents. The write is visible from the next cycle.
- rst mid-operation: abandons any stalled block. State is as at power-up one cycle later.
- Simultaneous rst and redirect: rst wins.

## Structure
- Shared package fetch_pkg holds:
  - state enum {S_RESET, S_RUN}
  - counter constants CNT_WEAK_TAKEN=2'd2, CNT_MAX=2'd3
  - a BTB entry struct
- Sub-module fetch_btb owns the entry array, the combinational lookup port and the update port.
- fetch_addr_gen owns the PC register, state machine, mask generation and next-PC mux.

## Test plan
All scenarios use default parameters.
- Reset release, out_ready=1, no BTB entries:
  - out_pc sequence 0x1C000000, 0x1C000010, 0x1C000020.
  - mask 4'b1111, pred_taken=0.
- Redirect to 0x1C00000C, then out_ready=1:
  - out_pc=0x1C00000C, mask 4'b1000.
  - next out_pc=0x1C000010.
- Update (0x1C000008 → 0x1C000100, taken), then redirect to 0x1C000000:
  - mask 4'b0111, pred_taken=1, pred_slot=2.
  - next out_pc=0x1C000100.
- Same entry, redirect to 0x1C00000C (offset 3 > slot 2):
  - miss, mask 4'b1000, next out_pc=0x1C000010.
- Counter hysteresis:
  - After allocate (counter=2), one not-taken update gives counter 1 → prediction off.
  - Two taken updates give counter 3. Then one not-taken leaves prediction on.
- Hold out_ready=0 for 5 cycles with a same-cycle redirect on cycle 3:
  - out_pc is stable on cycles 1–3 and equals redirect_pc on cycle 4.
  - rst on cycle 5 gives out_valid=0 on cycle 6 and out_pc=0x1C000000.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch-address generator and its BTB.
package fetch_pkg;

   typedef enum logic {
      S_RESET = 1'b0,
      S_RUN   = 1'b1
   } state_e;

   localparam logic [1:0] CNT_WEAK_TAKEN = 2'd2;
   localparam logic [1:0] CNT_MAX        = 2'd3;

   // Tag and slot are stored at fixed widths so the struct does not depend
   // on module parameters; unused upper bits are always zero.
   localparam int SLOT_W = 8;

   typedef struct packed {
      logic              valid;
      logic [31:0]       tag;
      logic [SLOT_W-1:0] slot;
      logic [31:0]       target;
      logic [1:0]        cnt;
   } btb_entry_t;

   // Saturating step of the 2-bit direction counter.
   function automatic logic [1:0] cnt_step(input logic [1:0] cnt, input logic taken);
      logic [1:0] res;
      res = cnt;
      if (taken) begin
         if (cnt != CNT_MAX) begin
            res = cnt + 2'd1;
         end
      end else begin
         if (cnt != 2'd0) begin
            res = cnt - 2'd1;
         end
      end
      return res;
   endfunction

   function automatic logic cnt_predicts_taken(input logic [1:0] cnt);
      return (cnt >= CNT_WEAK_TAKEN);
   endfunction

endpackage

// File: rtl/fetch_btb.sv
// Direct-mapped branch target buffer: combinational lookup port plus one
// training write port. Writes become visible the cycle after they are made.
module fetch_btb
   import fetch_pkg::*;
#(
   parameter int FETCH_WIDTH = 4,
   parameter int BTB_ENTRIES = 16
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [31:0]                    lk_pc,
   output logic                           lk_hit,
   output logic [$clog2(FETCH_WIDTH)-1:0] lk_slot,
   output logic [31:0]                    lk_target,
   input  logic                           upd_valid,
   input  logic [31:0]                    upd_pc,
   input  logic [31:0]                    upd_target,
   input  logic                           upd_taken
);

   localparam int OW      = $clog2(FETCH_WIDTH);
   localparam int IW      = $clog2(BTB_ENTRIES);
   localparam int TAG_LSB = OW + 2 + IW;

   btb_entry_t entries_q [BTB_ENTRIES];
   btb_entry_t entries_d [BTB_ENTRIES];

   logic [IW-1:0] lk_idx;
   logic [OW-1:0] lk_off;
   logic [31:0]   lk_tag;
   btb_entry_t    lk_entry;

   logic [IW-1:0] upd_idx;
   logic [OW-1:0] upd_off;
   logic [31:0]   upd_tag;
   btb_entry_t    upd_entry;

   assign lk_idx  = lk_pc[OW+2 +: IW];
   assign lk_off  = lk_pc[OW+1:2];
   assign lk_tag  = lk_pc >> TAG_LSB;

   assign upd_idx = upd_pc[OW+2 +: IW];
   assign upd_off = upd_pc[OW+1:2];
   assign upd_tag = upd_pc >> TAG_LSB;

   // Lookup: a hit needs a live entry for this tag whose branch lies at or after the start slot and predicts taken.
   always_comb begin
      lk_entry  = entries_q[lk_idx];
      lk_hit    = lk_entry.valid
                  && (lk_entry.tag == lk_tag)
                  && (lk_entry.slot >= SLOT_W'(lk_off))
                  && cnt_predicts_taken(lk_entry.cnt);
      lk_slot   = lk_entry.slot[OW-1:0];
      lk_target = lk_entry.target;
   end

   // Training: bump the counter on a tag hit (refreshing target/slot when taken), allocate on a taken miss; reset only drops valid bits.
   always_comb begin
      entries_d = entries_q;
      upd_entry = entries_q[upd_idx];
      if (upd_valid) begin
         if (upd_entry.valid && (upd_entry.tag == upd_tag)) begin
            upd_entry.cnt = cnt_step(upd_entry.cnt, upd_taken);
            if (upd_taken) begin
               upd_entry.target = upd_target;
               upd_entry.slot   = SLOT_W'(upd_off);
            end
         end else if (upd_taken) begin
            upd_entry.valid  = 1'b1;
            upd_entry.tag    = upd_tag;
            upd_entry.slot   = SLOT_W'(upd_off);
            upd_entry.target = upd_target;
            upd_entry.cnt    = CNT_WEAK_TAKEN;
         end
         entries_d[upd_idx] = upd_entry;
      end
      if (rst) begin
         for (int i = 0; i < BTB_ENTRIES; i++) begin
            entries_d[i].valid = 1'b0;
         end
      end
   end

   // Entry array register.
   always_ff @(posedge clk) begin
      entries_q <= entries_d;
   end

endmodule

// File: rtl/fetch_addr_gen.sv
// Fetch-address generator: holds the current block PC, presents one aligned
// fetch block per cycle and picks the next PC from the BTB, a redirect or
// the sequential path.
module fetch_addr_gen
   import fetch_pkg::*;
#(
   parameter int          FETCH_WIDTH = 4,
   parameter int          BTB_ENTRIES = 16,
   parameter logic [31:0] RESET_PC    = 32'h1C00_0000
) (
   input  logic                           clk,
   input  logic                           rst,
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic [31:0]                    out_pc,
   output logic [FETCH_WIDTH-1:0]         out_mask,
   output logic                           out_pred_taken,
   output logic [$clog2(FETCH_WIDTH)-1:0] out_pred_slot,
   output logic [31:0]                    out_pred_target,
   input  logic                           redirect_valid,
   input  logic [31:0]                    redirect_pc,
   input  logic                           upd_valid,
   input  logic [31:0]                    upd_pc,
   input  logic [31:0]                    upd_target,
   input  logic                           upd_taken
);

   localparam int OW          = $clog2(FETCH_WIDTH);
   localparam int BLOCK_BYTES = FETCH_WIDTH * 4;

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;

   logic          btb_hit;
   logic [OW-1:0] btb_slot;
   logic [31:0]   btb_target;

   logic [OW-1:0] start_off;
   logic [31:0]   seq_pc;
   logic [31:0]   pred_pc;

   fetch_btb #(
      .FETCH_WIDTH (FETCH_WIDTH),
      .BTB_ENTRIES (BTB_ENTRIES)
   ) u_btb (
      .clk        (clk),
      .rst        (rst),
      .lk_pc      (pc_q),
      .lk_hit     (btb_hit),
      .lk_slot    (btb_slot),
      .lk_target  (btb_target),
      .upd_valid  (upd_valid),
      .upd_pc     (upd_pc),
      .upd_target (upd_target),
      .upd_taken  (upd_taken)
   );

   assign out_pc    = pc_q;
   assign start_off = pc_q[OW+1:2];
   assign seq_pc    = (pc_q & ~32'(BLOCK_BYTES - 1)) + 32'(BLOCK_BYTES);

   // Two-state control: blocks are only offered once reset has been released.
   always_comb begin
      state_d   = state_q;
      out_valid = 1'b0;
      case (state_q)
         S_RESET: begin
            if (!rst) begin
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            out_valid = 1'b1;
            if (rst) begin
               state_d = S_RESET;
            end
         end
         default: begin
            state_d = S_RESET;
         end
      endcase
   end

   // Prediction outputs and slot mask; a miss zeroes the prediction fields and runs the mask to the block end.
   always_comb begin
      out_pred_taken  = btb_hit;
      out_pred_slot   = '0;
      out_pred_target = '0;
      pred_pc         = seq_pc;
      out_mask        = '0;
      if (btb_hit) begin
         out_pred_slot   = btb_slot;
         out_pred_target = btb_target;
         pred_pc         = btb_target;
      end
      for (int i = 0; i < FETCH_WIDTH; i++) begin
         out_mask[i] = (OW'(i) >= start_off) && (!btb_hit || (OW'(i) <= btb_slot));
      end
   end

   // Next-PC priority: reset, then redirect (dropping any same-cycle handshake), then an accepted block, else hold.
   always_comb begin
      pc_d = pc_q;
      if (rst) begin
         pc_d = RESET_PC;
      end else if (redirect_valid) begin
         pc_d = redirect_pc;
      end else if (out_valid && out_ready) begin
         pc_d = pred_pc;
      end
   end

   // State and PC registers.
   always_ff @(posedge clk) begin
      state_q <= state_d;
      pc_q    <= pc_d;
   end

endmodule
